mem_access: RTL and testbench
=============================

MEM_ACCESS -- requirements
Module: mem_access

Interface
REQ-001 The block SHALL have parameter DEPTH, default 256, meaning the number of 32-bit data-memory words (power of two).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates occur on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-004 The block SHALL have port wb_in, input, 2 bits: [1]=reg_write, [0]=mem_to_reg, from EX/MEM.
REQ-005 The block SHALL have port m, input, 2 bits: [1]=mem_read, [0]=mem_write.
REQ-006 The block SHALL have port alu_result, input, 32 bits: the byte address for loads/stores and the ALU value for non-memory instructions.
REQ-007 The block SHALL have port write_data, input, 32 bits: store data.
REQ-008 The block SHALL have port write_register_ex, input, 5 bits: destination register.
REQ-009 The block SHALL have port stall, input, 1 bit: hold the MEM/WB register.
REQ-010 The block SHALL have port flush, input, 1 bit: insert a bubble into MEM/WB.
REQ-011 The block SHALL have port wb, output, 2 bits: registered wb_in to the writeback stage.
REQ-012 The block SHALL have port read_data, output, 32 bits: registered load data.
REQ-013 The block SHALL have port address_WB, output, 32 bits: registered alu_result.
REQ-014 The block SHALL have port write_register_mem, output, 5 bits: registered destination register.
REQ-015 The block SHALL have port addr_error, output, 1 bit: registered misaligned-access flag.

Function
REQ-016 The block SHALL hold a DEPTH x 32 data memory indexed by alu_result[log2(DEPTH)+1:2]; upper address bits SHALL be ignored, so addresses wrap modulo DEPTH*4.
REQ-017 An access is active when m[1] or m[0] is 1; it SHALL be misaligned when alu_result[1:0] != 0.
REQ-018 A store (m[0]=1, aligned, stall=0, flush=0) SHALL write write_data into the indexed word at the clock edge.
REQ-019 A misaligned store, or any store with stall=1 or flush=1, SHALL leave memory unchanged.
REQ-020 A load (m[1]=1, aligned) SHALL register the indexed word into read_data one edge later, giving a latency of 1 cycle from input to output.
REQ-021 If m=2'b11, the load SHALL return the pre-write contents (read-before-write), and the write SHALL still occur.
REQ-022 On a non-load or misaligned access, the read_data register SHALL load 32'h0.
REQ-023 With stall=0 and flush=0, the MEM/WB register SHALL load wb<=wb_in, address_WB<=alu_result, and write_register_mem<=write_register_ex at each edge.
REQ-024 On a misaligned active access, the register SHALL load wb<=2'b00 and addr_error<=1; otherwise addr_error<=0.
REQ-025 With flush=1, the register SHALL load a bubble: wb=0, read_data=0, address_WB=0, write_register_mem=0, addr_error=0. flush SHALL take priority over stall.
REQ-026 With stall=1 and flush=0, all MEM/WB outputs SHALL hold their values.
REQ-027 addr_error SHALL be a one-cycle pulse per offending instruction, and SHALL remain asserted while held by a stall.

Reset
REQ-028 While rst=1, asynchronously, wb, read_data, address_WB, write_register_mem and addr_error SHALL be 0.
REQ-029 Memory contents SHALL NOT be affected by reset; they are undefined until written.
REQ-030 Reset asserted mid-operation SHALL discard the in-flight instruction, and no store SHALL occur at an edge where rst=1.
REQ-031 The first edge after rst falls SHALL capture inputs normally.

Verification
REQ-032 Store then load: store 32'hDEADBEEF at address 32'h10, then load with m=2'b10, alu_result=32'h10, wb_in=2'b11, write_register_ex=5 -> next cycle read_data=32'hDEADBEEF, wb=2'b11, write_register_mem=5.
REQ-033 Misaligned access: store with alu_result=32'h13 -> the word at 32'h10 is unchanged, addr_error=1 for one cycle, and wb=0.
REQ-034 Stall and flush: with stall=1 during a store to 32'h20 -> the memory word is unchanged and outputs hold; then flush=1 together with stall=1 -> all outputs are 0.
REQ-035 Read-before-write: with the word at 32'h0=1, m=2'b11, write_data=2 -> read_data=1, and a subsequent load returns 2.
REQ-036 Wrap and reset: with DEPTH=256, a store to 32'h400 and a load from 32'h0 return the same data; asserting rst mid-stream -> outputs go to 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/mem_access.sv
// -----------------------------------------------------------------------------
// mem_access: MEM pipeline stage with the data memory and the MEM/WB register.
//
// Loads and stores index a DEPTH x 32 word memory with alu_result[AW+1:2].
// Upper address bits are ignored, so addresses wrap modulo DEPTH*4. Every
// result is registered into MEM/WB, which supports stall (hold) and
// flush (bubble). Flush takes priority over stall.
//
// Ports
//   clk                in   stage clock, rising edge
//   rst                in   asynchronous active-high reset (clears MEM/WB only)
//   wb_in[1:0]         in   {reg_write, mem_to_reg} from EX/MEM
//   m[1:0]             in   {mem_read, mem_write}
//   alu_result[31:0]   in   byte address for loads/stores, or the ALU value
//   write_data[31:0]   in   store data
//   write_register_ex  in   destination register
//   stall              in   hold MEM/WB; stores are suppressed
//   flush              in   load a bubble into MEM/WB; stores are suppressed
//   wb[1:0]            out  registered wb_in (0 on a misaligned access)
//   read_data[31:0]    out  registered load data (0 on non-load or misaligned)
//   address_WB[31:0]   out  registered alu_result
//   write_register_mem out  registered destination register
//   addr_error         out  registered misaligned-access flag
// -----------------------------------------------------------------------------
module mem_access #(
  parameter int DEPTH = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  wb_in,
  input  logic [1:0]  m,
  input  logic [31:0] alu_result,
  input  logic [31:0] write_data,
  input  logic [4:0]  write_register_ex,
  input  logic        stall,
  input  logic        flush,
  output logic [1:0]  wb,
  output logic [31:0] read_data,
  output logic [31:0] address_WB,
  output logic [4:0]  write_register_mem,
  output logic        addr_error
);

  localparam int AW = $clog2(DEPTH);

  typedef struct packed {
    logic [1:0]  wb;
    logic [31:0] rdata;
    logic [31:0] addr;
    logic [4:0]  wreg;
    logic        err;
  } memwb_t;

  logic [31:0] r_mem [DEPTH];
  memwb_t      r_mwb;
  memwb_t      w_mwb_nxt;

  logic [AW-1:0] w_idx;
  logic          w_active;
  logic          w_misal;
  logic          w_load;
  logic          w_store;
  logic [31:0]   w_rdata;

  assign w_idx    = alu_result[AW+1:2];
  assign w_active = m[1] | m[0];
  assign w_misal  = w_active & (alu_result[1:0] != 2'b00);
  assign w_load   = m[1] & ~w_misal;
  assign w_store  = m[0] & ~w_misal & ~stall & ~flush;
  assign w_rdata  = r_mem[w_idx];

  // Memory is not reset; rst only gates the write so no store lands on an
  // edge where reset is asserted. The read above sees pre-write contents,
  // which gives read-before-write for m=2'b11.
  always_ff @(posedge clk) begin
    if (!rst && w_store) r_mem[w_idx] <= write_data;
  end

  always_comb begin
    w_mwb_nxt = r_mwb;
    if (flush) begin
      w_mwb_nxt = '0;
    end else if (!stall) begin
      w_mwb_nxt.wb    = w_misal ? 2'b00 : wb_in;
      w_mwb_nxt.rdata = w_load ? w_rdata : 32'h0;
      w_mwb_nxt.addr  = alu_result;
      w_mwb_nxt.wreg  = write_register_ex;
      w_mwb_nxt.err   = w_misal;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_mwb <= '0;
    else     r_mwb <= w_mwb_nxt;
  end

  assign wb                 = r_mwb.wb;
  assign read_data          = r_mwb.rdata;
  assign address_WB         = r_mwb.addr;
  assign write_register_mem = r_mwb.wreg;
  assign addr_error         = r_mwb.err;

endmodule

// File: tb/tb_mem_access.sv
// Scoreboard bench for mem_access: stimulus pushes expected MEM/WB contents
// computed by a word-array reference model; a monitor pops one entry after
// every rising edge and compares all outputs.
module tb_mem_access;
  localparam int DEPTH = 256;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  wb_in = '0;
  logic [1:0]  m = '0;
  logic [31:0] alu_result = '0;
  logic [31:0] write_data = '0;
  logic [4:0]  write_register_ex = '0;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic [1:0]  wb;
  logic [31:0] read_data;
  logic [31:0] address_WB;
  logic [4:0]  write_register_mem;
  logic        addr_error;

  mem_access #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .wb_in(wb_in), .m(m), .alu_result(alu_result),
    .write_data(write_data), .write_register_ex(write_register_ex),
    .stall(stall), .flush(flush), .wb(wb), .read_data(read_data),
    .address_WB(address_WB), .write_register_mem(write_register_mem),
    .addr_error(addr_error)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  wb;
    logic [31:0] rd;
    logic [31:0] addr;
    logic [4:0]  wr;
    logic        err;
  } exp_t;

  exp_t        sb[$];
  exp_t        prev;
  logic [31:0] model_mem [DEPTH];
  int          checks = 0;
  int          errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
    end
  endtask

  // One instruction: drive at the falling edge, predict the MEM/WB contents
  // after the next rising edge and push them to the scoreboard.
  task automatic cyc(input logic r, input logic [1:0] wbi, input logic [1:0] mi,
                     input logic [31:0] alu, input logic [31:0] wd,
                     input logic [4:0] wr, input logic st, input logic fl);
    exp_t e;
    bit   active, misal;
    int   idx;
    @(negedge clk);
    rst = r; wb_in = wbi; m = mi; alu_result = alu; write_data = wd;
    write_register_ex = wr; stall = st; flush = fl;
    active = (mi != 2'b00);
    misal  = active && (alu % 4 != 0);
    idx    = int'((alu / 4) % DEPTH);
    if (r || fl) begin
      e = '{2'b00, 32'h0, 32'h0, 5'd0, 1'b0};
    end else if (st) begin
      e = prev;
    end else begin
      e.wb   = misal ? 2'b00 : wbi;
      e.rd   = (mi[1] && !misal) ? model_mem[idx] : 32'h0;
      e.addr = alu;
      e.wr   = wr;
      e.err  = misal;
      if (mi[0] && !misal) model_mem[idx] = wd;
    end
    prev = e;
    sb.push_back(e);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("wb", {30'b0, wb}, {30'b0, e.wb});
        chk("read_data", read_data, e.rd);
        chk("address_WB", address_WB, e.addr);
        chk("write_register_mem", {27'b0, write_register_mem}, {27'b0, e.wr});
        chk("addr_error", {31'b0, addr_error}, {31'b0, e.err});
      end
    end
  end

  task automatic chk_zero(input string tag);
    chk({tag, "_wb"}, {30'b0, wb}, 32'h0);
    chk({tag, "_read_data"}, read_data, 32'h0);
    chk({tag, "_address_WB"}, address_WB, 32'h0);
    chk({tag, "_wreg"}, {27'b0, write_register_mem}, 32'h0);
    chk({tag, "_addr_error"}, {31'b0, addr_error}, 32'h0);
  endtask

  initial begin : stim
    logic [31:0] a;
    logic [1:0]  mm;
    prev = '{2'b00, 32'h0, 32'h0, 5'd0, 1'b0};
    #1;
    chk_zero("reset");
    cyc(1, 2'b11, 2'b10, 32'h0, 32'h0, 5'd3, 0, 0);
    // preload every word so the model never predicts undefined contents
    for (int i = 0; i < DEPTH; i++)
      cyc(0, 2'b00, 2'b01, 32'(i * 4), $urandom, 5'd0, 0, 0);

    // store then load
    cyc(0, 2'b00, 2'b01, 32'h10, 32'hDEADBEEF, 5'd0, 0, 0);
    cyc(0, 2'b11, 2'b10, 32'h10, 32'h0, 5'd5, 0, 0);
    // misaligned store leaves 0x10 intact, one-cycle error pulse
    cyc(0, 2'b11, 2'b01, 32'h13, 32'h12345678, 5'd7, 0, 0);
    cyc(0, 2'b11, 2'b10, 32'h10, 32'h0, 5'd6, 0, 0);
    // misaligned load held by a stall keeps addr_error high
    cyc(0, 2'b10, 2'b10, 32'h22, 32'h0, 5'd8, 0, 0);
    cyc(0, 2'b10, 2'b01, 32'h20, 32'h55555555, 5'd9, 1, 0);
    // stalled store to 0x20, then flush with stall
    cyc(0, 2'b11, 2'b10, 32'h20, 32'h0, 5'd4, 0, 0);
    cyc(0, 2'b00, 2'b01, 32'h20, 32'hAAAA5555, 5'd0, 1, 0);
    cyc(0, 2'b00, 2'b01, 32'h20, 32'h5555AAAA, 5'd0, 1, 1);
    cyc(0, 2'b11, 2'b10, 32'h20, 32'h0, 5'd4, 0, 0);
    // read-before-write
    cyc(0, 2'b00, 2'b01, 32'h0, 32'h1, 5'd0, 0, 0);
    cyc(0, 2'b11, 2'b11, 32'h0, 32'h2, 5'd1, 0, 0);
    cyc(0, 2'b11, 2'b10, 32'h0, 32'h0, 5'd1, 0, 0);
    // wrap: 0x400 aliases 0x0
    cyc(0, 2'b00, 2'b01, 32'h400, 32'hCAFEF00D, 5'd0, 0, 0);
    cyc(0, 2'b11, 2'b10, 32'h0, 32'h0, 5'd2, 0, 0);
    cyc(0, 2'b11, 2'b10, 32'h10, 32'h0, 5'd5, 0, 0);

    // asynchronous reset between edges with non-zero outputs
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk_zero("async_rst");
    prev = '{2'b00, 32'h0, 32'h0, 5'd0, 1'b0};
    cyc(1, 2'b00, 2'b01, 32'h10, 32'h0BADF00D, 5'd0, 0, 0);
    cyc(0, 2'b11, 2'b10, 32'h10, 32'h0, 5'd5, 0, 0);

    // random traffic
    for (int i = 0; i < 800; i++) begin
      mm = 2'($urandom);
      a  = ($urandom_range(0, 9) == 0) ? $urandom : 32'($urandom_range(0, 4095) & ~32'h3);
      if ($urandom_range(0, 7) == 0) a = a | 32'($urandom_range(1, 3));
      cyc($urandom_range(0, 59) == 0, 2'($urandom), mm, a, $urandom, 5'($urandom),
          $urandom_range(0, 6) == 0, $urandom_range(0, 9) == 0);
    end
    cyc(0, 2'b00, 2'b00, 32'h0, 32'h0, 5'd0, 0, 0);

    for (int k = 0; k < 10 && sb.size() > 0; k++) @(posedge clk);
    #2;
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d entries left, expected 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
